cover_toggle_sched: RTL and testbench

COVER_TOGGLE_SCHED -- requirements
Module: cover_toggle_sched

---
 rtl/cover_toggle_sched_if.sv | 9 +
 rtl/cover_toggle_sched.sv | 117 +++++++++++
 tb/tb_cover_toggle_sched.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cover_toggle_sched_if.sv
// Report-slot handshake between the toggle-cover scheduler and its consumer.
interface cover_toggle_sched_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;

  modport master (output out_valid, output out_index, input out_ready);
  modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/cover_toggle_sched.sv
// Toggle-cover event scheduler: captures per-bit hit strobes into a pending bitmap
// and drains them one per cycle, round-robin, into a single-entry report slot.
module cover_toggle_sched #(
  parameter int WIDTH       = 56,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 38253
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      valid,
  input  logic                  en,
  input  logic                  dedup,
  input  logic                  clear,
  cover_toggle_sched_if.master  rpt,
  output logic [31:0]           event_count,
  output logic [15:0]           merge_count
);

  localparam int RR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || WIDTH > 1024 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_params
    $error("cover_toggle_sched: WIDTH/COVER_INDEX outside COVER_TOTAL range");
  end

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] covered_q, covered_d;
  logic [RR_W-1:0]  rr_q, rr_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_index_q, out_index_d;
  logic [31:0]      event_count_q, event_count_d;
  logic [15:0]      merge_count_q, merge_count_d;

  logic [WIDTH-1:0] cap, cap_eff, loaded_oh;
  logic [RR_W-1:0]  g;
  logic             found, slot_free, load, merge_hit;

  // Circular priority search starting at the round-robin pointer.
  always_comb begin
    logic [RR_W:0]   sum;
    logic [RR_W-1:0] idx;
    found = 1'b0;
    g     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum = {1'b0, rr_q} + (RR_W+1)'(k);
      if (sum >= (RR_W+1)'(WIDTH)) sum = sum - (RR_W+1)'(WIDTH);
      idx = sum[RR_W-1:0];
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  always_comb begin
    slot_free = !out_valid_q || rpt.out_ready;
    load      = slot_free && found;

    loaded_oh = '0;
    if (load) loaded_oh[g] = 1'b1;

    // A clear pulse discards this cycle's hits along with the bitmaps.
    cap = '0;
    if (en && !clear) cap = valid & (dedup ? ~covered_q : {WIDTH{1'b1}});
    cap_eff   = cap & ~(dedup ? loaded_oh : '0);
    merge_hit = |(cap & pending_q & ~loaded_oh);

    pending_d = (pending_q & ~loaded_oh) | cap_eff;
    covered_d = covered_q | loaded_oh;
    if (clear) begin
      pending_d = '0;
      covered_d = '0;
    end

    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_index_d = 64'(COVER_INDEX) + 64'(g);
      rr_d        = (g == RR_W'(WIDTH-1)) ? '0 : g + 1'b1;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end

    event_count_d = event_count_q;
    if (out_valid_q && rpt.out_ready) event_count_d = event_count_q + 32'd1;

    merge_count_d = merge_count_q;
    if (merge_hit && merge_count_q != 16'hFFFF) merge_count_d = merge_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q     <= '0;
      covered_q     <= '0;
      rr_q          <= '0;
      out_valid_q   <= 1'b0;
      out_index_q   <= '0;
      event_count_q <= '0;
      merge_count_q <= '0;
    end else begin
      pending_q     <= pending_d;
      covered_q     <= covered_d;
      rr_q          <= rr_d;
      out_valid_q   <= out_valid_d;
      out_index_q   <= out_index_d;
      event_count_q <= event_count_d;
      merge_count_q <= merge_count_d;
    end
  end

  assign rpt.out_valid = out_valid_q;
  assign rpt.out_index = out_index_q;
  assign event_count   = event_count_q;
  assign merge_count   = merge_count_q;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Bench for cover_toggle_sched: directed scenarios plus randomized traffic checked
// against a bitmap-level reference model.
module tb_cover_toggle_sched;
  localparam int W  = 56;
  localparam int CI = 100;
  localparam int CT = 38253;

  logic         clk = 1'b0;
  logic         rst, en, dedup, clr;
  logic [W-1:0] vld;
  logic [31:0]  ev;
  logic [15:0]  mc;

  always #5 clk = ~clk;

  cover_toggle_sched_if ifc ();

  cover_toggle_sched #(.WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(CT)) dut (
    .clock       (clk),
    .reset       (rst),
    .valid       (vld),
    .en          (en),
    .dedup       (dedup),
    .clear       (clr),
    .rpt         (ifc),
    .event_count (ev),
    .merge_count (mc)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_pend[W];
  bit          m_cov[W];
  int          m_rr;
  bit          m_ov;
  logic [63:0] m_idx;
  logic [31:0] m_ev;
  int          m_mc;

  task automatic model_edge();
    int g;
    bit free, merged;
    bit capv[W];
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        m_pend[i] = 0;
        m_cov[i]  = 0;
      end
      m_rr = 0; m_ov = 0; m_idx = '0; m_ev = '0; m_mc = 0;
      return;
    end
    free = !m_ov || ifc.out_ready;
    g = -1;
    if (free)
      for (int k = 0; k < W; k++)
        if (g < 0 && m_pend[(m_rr + k) % W]) g = (m_rr + k) % W;
    merged = 0;
    for (int i = 0; i < W; i++) begin
      capv[i] = !clr && en && vld[i] && !(dedup && (m_cov[i] || i == g));
      if (capv[i] && m_pend[i] && i != g) merged = 1;
    end
    if (m_ov && ifc.out_ready) m_ev++;
    if (merged && m_mc < 65535) m_mc++;
    if (g >= 0) begin
      m_ov = 1;
      m_idx = 64'(CI + g);
      m_pend[g] = 0;
      m_cov[g] = 1;
      m_rr = (g + 1) % W;
    end else if (free) begin
      m_ov = 0;
    end
    for (int i = 0; i < W; i++) if (capv[i]) m_pend[i] = 1;
    if (clr)
      for (int i = 0; i < W; i++) begin
        m_pend[i] = 0;
        m_cov[i]  = 0;
      end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", 64'(ifc.out_valid), 64'(m_ov));
    chk("out_index", ifc.out_index, m_idx);
    chk("event_count", 64'(ev), 64'(m_ev));
    chk("merge_count", 64'(mc), 64'(m_mc));
    if (ifc.out_valid) chk("idx_range", 64'(ifc.out_index < CT), 64'd1);
  endtask

  longint unsigned seen[$];
  logic [31:0]     ev_base;
  logic [63:0]     r;
  longint unsigned nxt;
  int              n;

  initial begin
    rst = 1'b1; en = 1'b0; dedup = 1'b0; clr = 1'b0; vld = '0;
    ifc.out_ready = 1'b0;
    step(); step();
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_index", ifc.out_index, 64'd0);
    chk("rst_evcnt", 64'(ev), 64'd0);
    chk("rst_mgcnt", 64'(mc), 64'd0);
    rst = 1'b0;

    // Two hits in one cycle: latency two, then back-to-back
    ifc.out_ready = 1'b1; en = 1'b1;
    vld = (56'd1 << 3) | (56'd1 << 40);
    step();
    vld = '0;
    step();
    chk("lat_valid", 64'(ifc.out_valid), 64'd1);
    chk("lat_idx0", ifc.out_index, 64'd103);
    step();
    chk("lat_idx1", ifc.out_index, 64'd140);
    step();
    chk("lat_evcnt", 64'(ev), 64'd2);
    chk("lat_idle", 64'(ifc.out_valid), 64'd0);

    // Dedup: repeated hits report once, clear re-arms the point
    dedup = 1'b1; ev_base = ev;
    repeat (4) begin
      vld = 56'd1 << 5; step();
      vld = '0; repeat (9) step();
    end
    chk("dedup_once", 64'(ev - ev_base), 64'd1);
    clr = 1'b1; step(); clr = 1'b0;
    vld = 56'd1 << 5; step();
    vld = '0; repeat (4) step();
    chk("dedup_rearm", 64'(ev - ev_base), 64'd2);
    chk("dedup_idx", ifc.out_index, 64'd105);

    // Backpressure with a constantly re-hit point
    dedup = 1'b0; ifc.out_ready = 1'b0; ev_base = ev;
    vld = 56'd1 << 7;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 2) chk("hold_idx", ifc.out_index, 64'd107);
    end
    chk("hold_valid", 64'(ifc.out_valid), 64'd1);
    vld = '0; ifc.out_ready = 1'b1;
    step();
    chk("rereport_idx", ifc.out_index, 64'd107);
    chk("rereport_valid", 64'(ifc.out_valid), 64'd1);
    step();
    chk("rereport_cnt", 64'(ev - ev_base), 64'd2);

    // Round-robin over all points held high
    clr = 1'b1; step(); clr = 1'b0;
    n = 0;
    while (ifc.out_valid && n < 10) begin step(); n++; end
    chk("drain", 64'(ifc.out_valid), 64'd0);
    vld = '1;
    for (int i = 0; i < 130; i++) begin
      step();
      if (ifc.out_valid) seen.push_back(ifc.out_index);
    end
    chk("rr_count", 64'(seen.size() >= 2 * W), 64'd1);
    for (int i = 1; i < seen.size(); i++) begin
      nxt = (seen[i-1] == CI + W - 1) ? CI : seen[i-1] + 1;
      chk("rr_seq", seen[i], nxt);
    end
    vld = '0;
    clr = 1'b1; step(); clr = 1'b0;
    repeat (3) step();

    // Reset while an event is held
    ifc.out_ready = 1'b0;
    vld = 56'd1 << 9; step();
    vld = '0; step(); step();
    chk("held_valid", 64'(ifc.out_valid), 64'd1);
    chk("held_idx", ifc.out_index, 64'd109);
    rst = 1'b1; step();
    chk("drop_valid", 64'(ifc.out_valid), 64'd0);
    chk("drop_evcnt", 64'(ev), 64'd0);
    chk("drop_mgcnt", 64'(mc), 64'd0);
    rst = 1'b0; ifc.out_ready = 1'b1;
    repeat (3) step();
    chk("drop_quiet", 64'(ev), 64'd0);
    chk("drop_quiet_v", 64'(ifc.out_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      en    = ($urandom_range(0, 3) != 0);
      dedup = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      vld = ($urandom_range(0, 1) == 0) ? '0 : r[W-1:0];
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
